// File: rtl/vr_wiper_rx.sv
// vr_wiper_rx: responder end of a three-wire up/down digital potentiometer
// interface. CS/UD/CLKIN are synchronized into clk, edge-detected, and
// decoded into a saturating wiper position plus a stored (nonvolatile) copy.
module vr_wiper_rx #(
  parameter int WIDTH   = 6,
  parameter int MAX     = 63,
  parameter int DEFAULT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CS,
  input  logic             UD,
  input  logic             CLKIN,
  output logic [WIDTH-1:0] wiper,
  output logic [WIDTH-1:0] nv_wiper,
  output logic             active,
  output logic             step,
  output logic             sat,
  output logic             store
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] DEF_C = WIDTH'(DEFAULT);
  // Bit order {CLKIN, UD, CS}; idle bus levels are CLKIN=1, UD=0, CS=1.
  localparam logic [2:0]       SYNC_RST = 3'b101;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [2:0]       s1_q, s2_q, prev_q;
  logic [1:0]       vld_q;
  logic             armed_q, armed_d;
  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] wiper_q, wiper_d;
  logic [WIDTH-1:0] nv_q, nv_d;
  logic             step_q, step_d;
  logic             sat_q, sat_d;
  logic             store_q, store_d;

  logic cs_s2, ud_s2, clkin_s2, cs_prev, clkin_prev;
  logic cs_fall, cs_rise, clk_fall;

  assign cs_s2      = s2_q[0];
  assign ud_s2      = s2_q[1];
  assign clkin_s2   = s2_q[2];
  assign cs_prev    = prev_q[0];
  assign clkin_prev = prev_q[2];

  assign cs_fall  = ~cs_s2 & cs_prev;
  assign cs_rise  = cs_s2 & ~cs_prev;
  assign clk_fall = ~clkin_s2 & clkin_prev;

  // Two-flop synchronizers plus a previous-value stage for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= SYNC_RST;
      s2_q   <= SYNC_RST;
      prev_q <= SYNC_RST;
    end else begin
      s1_q   <= {CLKIN, UD, CS};
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // The synchronizer reset value makes CS look high, so a CS held low across
  // reset release would otherwise appear as a fresh fall. vld_q marks when s2
  // holds a real sample; a transaction may only open once CS was seen high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_d;
    end
  end

  assign armed_d = armed_q | (vld_q[1] & cs_s2);

  // Transaction state, wiper, stored copy and one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      wiper_q <= DEF_C;
      nv_q    <= DEF_C;
      step_q  <= 1'b0;
      sat_q   <= 1'b0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      wiper_q <= wiper_d;
      nv_q    <= nv_d;
      step_q  <= step_d;
      sat_q   <= sat_d;
      store_q <= store_d;
    end
  end

  // Next-state decode: open on CS fall, step on CLKIN fall, close on CS rise
  // with a store when CLKIN is held high at the release.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    wiper_d = wiper_q;
    nv_d    = nv_q;
    step_d  = 1'b0;
    sat_d   = 1'b0;
    store_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          dir_d   = ud_s2;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (clk_fall) begin
          if (dir_q) begin
            if (wiper_q < MAX_C) begin
              wiper_d = wiper_q + WIDTH'(1);
              step_d  = 1'b1;
            end else begin
              sat_d = 1'b1;
            end
          end else begin
            if (wiper_q != '0) begin
              wiper_d = wiper_q - WIDTH'(1);
              step_d  = 1'b1;
            end else begin
              sat_d = 1'b1;
            end
          end
        end
        if (cs_rise) begin
          state_d = IDLE;
          // clkin_s2 high excludes a same-cycle step, so wiper_q is the
          // pre-step value either way.
          if (clkin_s2) begin
            nv_d    = wiper_q;
            store_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wiper    = wiper_q;
  assign nv_wiper = nv_q;
  assign active   = (state_q == ACTIVE);
  assign step     = step_q;
  assign sat      = sat_q;
  assign store    = store_q;

endmodule
